// File: rtl/l2_input_arbiter_param.sv
// l2_input_arbiter_param
//   Parametrised L2 input arbiter. Each decode slot it picks one of NUM_CH
//   requesting channels (fence, rsp, fwd, cpu_req, internal replays, ...).
//   The winner is registered together with its address split into
//   tag/set/word-offset/byte-offset for the L2 pipeline.
//   Selection supports fixed priority (index 0 highest) or round-robin.
//   Per-channel aging counters promote a channel that keeps losing.
//   A held internal request on a channel takes precedence over that
//   channel's external valid.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   decode_en          pipeline accepts a decode this cycle
//   mode_rr            0 = fixed priority, 1 = round-robin
//   ch_valid           external request per channel
//   ch_internal        held internal (replay) request per channel
//   ch_eligible        external gating per channel
//   ch_addr            packed byte addresses, channel i at [i*ADDR_W +: ADDR_W]
//   ch_ready           comb: external request of the winner accepted
//   ch_take_internal   comb: internal request of the winner consumed
//   grant_next         comb: one-hot winner (or zero)
//   grant, grant_id, grant_valid, starved     registered grant state
//   line_addr, tag, set, w_off, b_off         registered winner address fields

module l2_input_arbiter_param #(
  parameter int NUM_CH       = 4,
  parameter int ADDR_W       = 32,
  parameter int B_OFF_BITS   = 2,
  parameter int W_OFF_BITS   = 2,
  parameter int SET_BITS     = 8,
  parameter int STARVE_LIMIT = 7,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 decode_en,
  input  logic                                                 mode_rr,
  input  logic [NUM_CH-1:0]                                    ch_valid,
  input  logic [NUM_CH-1:0]                                    ch_internal,
  input  logic [NUM_CH-1:0]                                    ch_eligible,
  input  logic [NUM_CH*ADDR_W-1:0]                             ch_addr,
  output logic [NUM_CH-1:0]                                    ch_ready,
  output logic [NUM_CH-1:0]                                    ch_take_internal,
  output logic [NUM_CH-1:0]                                    grant_next,
  output logic [NUM_CH-1:0]                                    grant,
  output logic [$clog2(NUM_CH)-1:0]                            grant_id,
  output logic                                                 grant_valid,
  output logic [NUM_CH-1:0]                                    starved,
  output logic [ADDR_W-B_OFF_BITS-W_OFF_BITS-1:0]              line_addr,
  output logic [ADDR_W-B_OFF_BITS-W_OFF_BITS-SET_BITS-1:0]     tag,
  output logic [SET_BITS-1:0]                                  set,
  output logic [W_OFF_BITS-1:0]                                w_off,
  output logic [B_OFF_BITS-1:0]                                b_off
);

  localparam int IDX_W  = $clog2(NUM_CH);
  localparam int LINE_W = ADDR_W - B_OFF_BITS - W_OFF_BITS;
  localparam int TAG_W  = LINE_W - SET_BITS;
  localparam int LOW_W  = B_OFF_BITS + W_OFF_BITS;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [NUM_CH-1:0]             req;
  logic [NUM_CH-1:0]             starve_hit;
  logic [NUM_CH-1:0]             rot;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_nxt;
  logic [IDX_W-1:0]              rr_ptr;
  logic [IDX_W-1:0]              rr_nxt;
  logic [IDX_W-1:0]              win_idx;
  logic [IDX_W:0]                rr_sum;
  logic                          win_found;
  logic [ADDR_W-1:0]             win_addr;

  // decode_en folds into the request so every combinational output is
  // naturally zero when the pipeline is not accepting.
  always_comb begin
    req = (ch_valid | ch_internal) & ch_eligible & {NUM_CH{decode_en}};
  end

  always_comb begin
    starve_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      starve_hit[i] = req[i] && (cnt_q[i] == LIMIT);
    end
  end

  // Winner selection. Loops run from the top index down so the last hit
  // assigned is the lowest index (or the nearest to rr_ptr in RR mode).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_sum    = '0;
    // Rotate the request vector so bit k corresponds to channel rr_ptr+k.
    rot       = NUM_CH'({req, req} >> rr_ptr);

    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (starve_hit[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end

    if (!win_found) begin
      if (!mode_rr) begin
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (req[i]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(i);
          end
        end
      end else begin
        for (int k = NUM_CH - 1; k >= 0; k--) begin
          if (rot[k]) begin
            win_found = 1'b1;
            rr_sum    = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (rr_sum >= (IDX_W+1)'(NUM_CH)) begin
              rr_sum = rr_sum - (IDX_W+1)'(NUM_CH);
            end
            win_idx = rr_sum[IDX_W-1:0];
          end
        end
      end
    end
  end

  // Decode the winner into one-hot grant, handshake pulses and its address.
  // An internal replay on the winning channel is consumed in preference to
  // the external request, which then retries on a later slot.
  always_comb begin
    grant_next       = '0;
    ch_ready         = '0;
    ch_take_internal = '0;
    win_addr         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_found && (win_idx == IDX_W'(i))) begin
        grant_next[i] = 1'b1;
        win_addr      = ch_addr[i*ADDR_W +: ADDR_W];
        if (ch_internal[i]) begin
          ch_take_internal[i] = 1'b1;
        end else begin
          ch_ready[i] = 1'b1;
        end
      end
    end
  end

  // Aging: clear when granted or not requesting, otherwise count up and
  // saturate at the limit. Holds while decode is disabled.
  always_comb begin
    cnt_nxt = cnt_q;
    if (decode_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant_next[i] || !req[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt_q[i] != LIMIT) begin
          cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    if (win_idx == IDX_W'(NUM_CH - 1)) begin
      rr_nxt = '0;
    end else begin
      rr_nxt = win_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      starved     <= '0;
      line_addr   <= '0;
      tag         <= '0;
      set         <= '0;
      w_off       <= '0;
      b_off       <= '0;
      rr_ptr      <= '0;
      cnt_q       <= '0;
    end else if (decode_en) begin
      grant       <= grant_next;
      grant_id    <= win_idx;
      grant_valid <= win_found;
      cnt_q       <= cnt_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        starved[i] <= (cnt_nxt[i] == LIMIT);
      end
      // The pointer only advances on an RR grant; fixed mode leaves it be so
      // a later switch back to RR resumes where it left off.
      if (mode_rr && win_found) begin
        rr_ptr <= rr_nxt;
      end
      // win_addr is zero when there is no winner, clearing the fields.
      line_addr <= win_addr[ADDR_W-1:LOW_W];
      tag       <= win_addr[ADDR_W-1:ADDR_W-TAG_W];
      set       <= win_addr[LOW_W +: SET_BITS];
      w_off     <= win_addr[B_OFF_BITS +: W_OFF_BITS];
      b_off     <= win_addr[B_OFF_BITS-1:0];
    end
  end

endmodule

// File: tb/tb_l2_input_arbiter_param.sv
// tb_l2_input_arbiter_param
//   Directed bench for l2_input_arbiter_param with default parameters.
//   Inputs change #1 after a posedge; combinational outputs are checked
//   before the next posedge and registered outputs #1 after it.

module tb_l2_input_arbiter_param;

  logic        clk;
  logic        rst;
  logic        decode_en;
  logic        mode_rr;
  logic [3:0]  ch_valid;
  logic [3:0]  ch_internal;
  logic [3:0]  ch_eligible;
  logic [127:0] ch_addr;
  logic [3:0]  ch_ready;
  logic [3:0]  ch_take_internal;
  logic [3:0]  grant_next;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        grant_valid;
  logic [3:0]  starved;
  logic [27:0] line_addr;
  logic [19:0] tag;
  logic [7:0]  set;
  logic [1:0]  w_off;
  logic [1:0]  b_off;

  int n_cmp = 0;
  int n_err = 0;

  l2_input_arbiter_param dut (
    .clk              (clk),
    .rst              (rst),
    .decode_en        (decode_en),
    .mode_rr          (mode_rr),
    .ch_valid         (ch_valid),
    .ch_internal      (ch_internal),
    .ch_eligible      (ch_eligible),
    .ch_addr          (ch_addr),
    .ch_ready         (ch_ready),
    .ch_take_internal (ch_take_internal),
    .grant_next       (grant_next),
    .grant            (grant),
    .grant_id         (grant_id),
    .grant_valid      (grant_valid),
    .starved          (starved),
    .line_addr        (line_addr),
    .tag              (tag),
    .set              (set),
    .w_off            (w_off),
    .b_off            (b_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic dec, input logic rr, input logic [3:0] v,
                       input logic [3:0] in, input logic [3:0] el);
    decode_en   = dec;
    mode_rr     = rr;
    ch_valid    = v;
    ch_internal = in;
    ch_eligible = el;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ch0 0xABCDEF01: tag ABCDE set F0 w0 b1
  // ch1 0x00001234: tag 00001 set 23 w1 b0, line 123
  // ch2 0x80000FFF: tag 80000 set FF w3 b3
  // ch3 0x12345678: tag 12345 set 67 w2 b0
  initial begin
    rst = 1'b0;
    ch_addr = {32'h1234_5678, 32'h8000_0FFF, 32'h0000_1234, 32'hABCD_EF01};
    drive(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000);

    // Reset values
    do_reset();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_grant_valid", grant_valid, 1'b0);
    chk("rst_grant_id", grant_id, 2'd0);
    chk("rst_starved", starved, 4'b0000);
    chk("rst_line", line_addr, 28'h0);
    chk("rst_tag", tag, 20'h0);

    // Fixed priority, basic decode
    drive(1'b1, 1'b0, 4'b1010, 4'b0000, 4'b1111);
    chk("fx_ready", ch_ready, 4'b0010);
    chk("fx_gnext", grant_next, 4'b0010);
    chk("fx_take", ch_take_internal, 4'b0000);
    tick();
    chk("fx_grant", grant, 4'b0010);
    chk("fx_id", grant_id, 2'd1);
    chk("fx_gv", grant_valid, 1'b1);
    chk("fx_set", set, 8'h23);
    chk("fx_woff", w_off, 2'd1);
    chk("fx_boff", b_off, 2'd0);
    chk("fx_tag", tag, 20'h00001);
    chk("fx_line", line_addr, 28'h0000123);

    // Starvation of ch3 behind ch0
    do_reset();
    drive(1'b1, 1'b0, 4'b1001, 4'b0000, 4'b1111);
    for (int c = 0; c < 7; c++) begin
      chk("stv_gnext_ch0", grant_next, 4'b0001);
      tick();
      chk("stv_grant_ch0", grant, 4'b0001);
    end
    chk("stv_starved_set", starved, 4'b1000);
    chk("stv_gnext_ch3", grant_next, 4'b1000);
    chk("stv_ready_ch3", ch_ready, 4'b1000);
    tick();
    chk("stv_grant_ch3", grant, 4'b1000);
    chk("stv_id_ch3", grant_id, 2'd3);
    chk("stv_tag_ch3", tag, 20'h12345);
    chk("stv_woff_ch3", w_off, 2'd2);
    chk("stv_starved_clr", starved, 4'b0000);
    chk("stv_after_gnext", grant_next, 4'b0001);

    // Round-robin rotation and pointer wrap
    do_reset();
    drive(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1111);
    for (int c = 0; c < 5; c++) begin
      chk("rr_gnext", grant_next, 4'b0001 << (c % 4));
      tick();
      chk("rr_id", grant_id, 64'(c % 4));
    end
    // Fixed mode does not move the pointer (left at 1)
    drive(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b1111);
    chk("rr_fixed_gnext", grant_next, 4'b0001);
    tick();
    drive(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1111);
    chk("rr_resume_gnext", grant_next, 4'b0010);
    tick();

    // Internal replay beats external on the same channel
    do_reset();
    drive(1'b1, 1'b0, 4'b0100, 4'b0100, 4'b1111);
    chk("int_take", ch_take_internal, 4'b0100);
    chk("int_ready", ch_ready, 4'b0000);
    chk("int_gnext", grant_next, 4'b0100);
    tick();
    chk("int_grant", grant, 4'b0100);
    chk("int_boff", b_off, 2'd3);
    chk("int_set", set, 8'hFF);
    drive(1'b1, 1'b0, 4'b0100, 4'b0000, 4'b1111);
    chk("int_ext_ready", ch_ready, 4'b0100);
    chk("int_ext_take", ch_take_internal, 4'b0000);
    tick();

    // Gating: valid but not eligible
    drive(1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    chk("gate_gnext", grant_next, 4'b0000);
    chk("gate_ready", ch_ready, 4'b0000);
    tick();
    chk("gate_gv", grant_valid, 1'b0);
    chk("gate_grant", grant, 4'b0000);
    chk("gate_line", line_addr, 28'h0);
    chk("gate_set", set, 8'h00);
    chk("gate_starved", starved, 4'b0000);

    // decode_en low holds registers
    drive(1'b1, 1'b0, 4'b1000, 4'b0000, 4'b1111);
    tick();
    chk("hold_pre_grant", grant, 4'b1000);
    drive(1'b0, 1'b0, 4'b0001, 4'b0000, 4'b1111);
    chk("hold_gnext", grant_next, 4'b0000);
    chk("hold_ready", ch_ready, 4'b0000);
    tick();
    tick();
    tick();
    chk("hold_grant", grant, 4'b1000);
    chk("hold_id", grant_id, 2'd3);
    chk("hold_tag", tag, 20'h12345);
    chk("hold_gv", grant_valid, 1'b1);

    // Reset mid-arbitration: rr_ptr=2 then counter[3]=5
    do_reset();
    drive(1'b1, 1'b1, 4'b0010, 4'b0000, 4'b1111);
    tick();
    drive(1'b1, 1'b0, 4'b1001, 4'b0000, 4'b1111);
    for (int c = 0; c < 5; c++) tick();
    chk("mid_pre_gv", grant_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_grant", grant, 4'b0000);
    chk("mid_gv", grant_valid, 1'b0);
    chk("mid_id", grant_id, 2'd0);
    chk("mid_tag", tag, 20'h0);
    drive(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1111);
    chk("mid_rrptr", grant_next, 4'b0001);
    tick();
    drive(1'b1, 1'b0, 4'b1001, 4'b0000, 4'b1111);
    for (int c = 0; c < 3; c++) begin
      chk("mid_cnt_clear", grant_next, 4'b0001);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
